// File: rtl/sccb_init_sequencer.sv
// SCCB sensor bring-up sequencer: after a power-up wait, walks a {reg,val} table and
// issues one SCCB write per entry, honouring 0xFE millisecond delays and the 0xFFFF end marker.
module sccb_init_sequencer #(
    parameter logic [7:0]  DEVICE_ID   = 8'h60,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned CYC_PER_MS  = 50_000,
    parameter int unsigned POWERUP_MS  = 3,
    parameter int unsigned TIMEOUT_CYC = 200_000
) (
    input  logic              XCLK,
    input  logic              RST,
    input  logic              init_start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_req,
    output logic [7:0]        sccb_addr_id,
    output logic [7:0]        sccb_addr_reg,
    output logic [7:0]        sccb_data,
    input  logic              sccb_busy,
    input  logic              sccb_done,
    output logic              init_busy,
    output logic              init_done,
    output logic              init_error,
    output logic [ADDR_W-1:0] entry_cnt
);
    localparam logic [31:0]       PWR_LOAD  = 32'(POWERUP_MS * CYC_PER_MS);
    localparam logic [31:0]       TMO_LOAD  = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0]       CPM_W     = 32'(CYC_PER_MS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_PWR_WAIT, S_FETCH, S_DECODE, S_ISSUE,
        S_WAIT_DONE, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ADDR_W-1:0] r_entry_cnt;
    logic [7:0]        r_addr_id;
    logic [7:0]        r_addr_reg;
    logic [7:0]        r_data;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic w_req;
    logic w_advance;
    logic w_end_marker;
    logic w_is_delay;
    logic w_last;
    logic w_cnt_exp;

    assign w_end_marker = (rom_data == 16'hFFFF);
    assign w_is_delay   = (rom_data[15:8] == 8'hFE);
    assign w_last       = (r_rom_addr == LAST_ADDR);
    // All waits load a count and step down; expiry at 1 gives exactly 'load' cycles.
    assign w_cnt_exp    = (r_cnt <= 32'd1);

    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (init_start) w_next = S_PWR_WAIT;
            S_PWR_WAIT: if (w_cnt_exp) w_next = S_FETCH;
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                if (w_end_marker)                w_next = S_DONE;
                else if (!w_is_delay)            w_next = S_ISSUE;
                else if (rom_data[7:0] != 8'h00) w_next = S_DELAY;
                else                             w_advance = 1'b1;
            end
            S_ISSUE: begin
                if (!sccb_busy) begin
                    w_req  = 1'b1;
                    w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (sccb_done)      w_advance = 1'b1;
                else if (w_cnt_exp) w_next = S_ERROR;
            end
            S_DELAY: if (w_cnt_exp) w_advance = 1'b1;
            default: w_next = S_IDLE;
        endcase
        // Moving past the final table slot ends the run rather than wrapping to 0.
        if (w_advance) w_next = w_last ? S_DONE : S_FETCH;
    end

    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            r_cnt       <= '0;
            r_rom_addr  <= '0;
            r_entry_cnt <= '0;
            r_addr_id   <= '0;
            r_addr_reg  <= '0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (init_start) begin
                        r_cnt       <= PWR_LOAD;
                        r_rom_addr  <= '0;
                        r_entry_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                    end
                end
                S_PWR_WAIT, S_DELAY: r_cnt <= r_cnt - 32'd1;
                S_DECODE: begin
                    if (!w_end_marker) begin
                        if (w_is_delay) begin
                            r_cnt <= 32'(rom_data[7:0]) * CPM_W;
                        end else begin
                            r_addr_id  <= DEVICE_ID & 8'hFE;
                            r_addr_reg <= rom_data[15:8];
                            r_data     <= rom_data[7:0];
                        end
                    end
                end
                S_ISSUE: if (w_req) r_cnt <= TMO_LOAD;
                S_WAIT_DONE: begin
                    r_cnt <= r_cnt - 32'd1;
                    if (sccb_done) r_entry_cnt <= r_entry_cnt + ADDR_W'(1);
                end
                default: ;
            endcase
            if (w_advance && !w_last) r_rom_addr <= r_rom_addr + ADDR_W'(1);
            if ((w_next == S_DONE) && (r_state != S_DONE)) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            if ((w_next == S_ERROR) && (r_state != S_ERROR)) begin
                r_error <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign rom_addr      = r_rom_addr;
    assign sccb_req      = w_req;
    assign sccb_addr_id  = r_addr_id;
    assign sccb_addr_reg = r_addr_reg;
    assign sccb_data     = r_data;
    assign init_busy     = r_busy;
    assign init_done     = r_done;
    assign init_error    = r_error;
    assign entry_cnt     = r_entry_cnt;
endmodule
